led_seg_lbus: RTL

Local-bus output peripheral: the write-side counterpart of the key/switch input block. Holds CPU-written LED and 4-digit seven-segment registers on the XT local bus. Drives 8 discrete LEDs and a multiplexed common-anode 4-digit display with PWM brightness, per-digit blink and ghost-free digit switching. Sits among the bus peripherals and returns readback through the same `rdata` mux style as its input-side sibling.

---
 rtl/led_seg_lbus_pkg.sv | 36 +++
 rtl/led_seg_lbus_hex7seg.sv | 29 ++
 rtl/led_seg_lbus.sv | 116 +++++++++++
 3 files changed

// File: rtl/led_seg_lbus_pkg.sv
// XT local-bus slave view, address decode helpers and the LED/seven-segment peripheral register map.
package XT_LBUS_Pkg;

   localparam int unsigned LB_AW = 16;
   localparam int unsigned LB_DW = 16;

   typedef struct packed {
      logic [LB_AW-1:0] addr;
      logic             wr;
      logic             rd;
      logic [LB_DW-1:0] wdata;
   } lb_slave_t;

   localparam logic [LB_AW-1:0] LED_SEG_OFS_LED    = 16'h0000;
   localparam logic [LB_AW-1:0] LED_SEG_OFS_DIGITS = 16'h0002;
   localparam logic [LB_AW-1:0] LED_SEG_OFS_CTRL   = 16'h0004;
   localparam logic [LB_AW-1:0] LED_SEG_OFS_STATUS = 16'h0006;

   typedef struct packed {
      logic [3:0] blink;
      logic [3:0] bright;
      logic [3:0] dp;
      logic [3:0] en;
   } led_seg_ctrl_t;

   localparam led_seg_ctrl_t LED_SEG_CTRL_RST = '{blink: 4'h0, bright: 4'hF, dp: 4'h0, en: 4'h0};

   function automatic logic MatchWLB(input lb_slave_t lb, input logic [LB_AW-1:0] addr);
      return lb.wr && (lb.addr == addr);
   endfunction

   function automatic logic MatchRLB(input lb_slave_t lb, input logic [LB_AW-1:0] addr);
      return lb.rd && (lb.addr == addr);
   endfunction

endpackage

// File: rtl/led_seg_lbus_hex7seg.sv
// Combinational hex digit to active-high segment decoder, seg = {g,f,e,d,c,b,a}; b and d are lowercase.
module hex7seg (
   input  logic [3:0] hex,
   output logic [6:0] seg
);

   always_comb begin
      seg = '0;
      case (hex)
         4'h0:    seg = 7'h3F;
         4'h1:    seg = 7'h06;
         4'h2:    seg = 7'h5B;
         4'h3:    seg = 7'h4F;
         4'h4:    seg = 7'h66;
         4'h5:    seg = 7'h6D;
         4'h6:    seg = 7'h7D;
         4'h7:    seg = 7'h07;
         4'h8:    seg = 7'h7F;
         4'h9:    seg = 7'h6F;
         4'hA:    seg = 7'h77;
         4'hB:    seg = 7'h7C;
         4'hC:    seg = 7'h39;
         4'hD:    seg = 7'h5E;
         4'hE:    seg = 7'h79;
         default: seg = 7'h71;
      endcase
   end

endmodule

// File: rtl/led_seg_lbus.sv
// CPU-written LED and 4-digit common-anode seven-segment registers on the XT local bus,
// scanned with PWM brightness, per-digit blink and a blank slot ahead of each digit to avoid ghosting.
module led_seg_lbus
   import XT_LBUS_Pkg::*;
#(
   parameter int unsigned PRESCALE = 1000
) (
   input  logic        lb_clk,
   input  logic        rst,
   input  lb_slave_t   xt_lb,
   output logic [15:0] rdata,
   output logic [7:0]  led,
   output logic [7:0]  seg_n,
   output logic [3:0]  dig_n
);

   localparam int unsigned     PS_W   = $clog2(PRESCALE);
   localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

   logic [7:0]      led_q, led_d;
   logic [15:0]     digits_q, digits_d;
   led_seg_ctrl_t   ctrl_q, ctrl_d;
   logic [PS_W-1:0] ps_q, ps_d;
   logic [3:0]      pc_q, pc_d;
   logic [1:0]      idx_q, idx_d;
   logic [7:0]      frame_q, frame_d;
   logic            phase_q, phase_d;
   logic [7:0]      seg_n_q, seg_n_d;
   logic [3:0]      dig_n_q, dig_n_d;

   logic            tick, pc_wrap, idx_wrap, frame_wrap, lit;
   logic [3:0]      cur_nib;
   logic [6:0]      cur_glyph;

   always_comb begin
      led_d    = led_q;
      digits_d = digits_q;
      ctrl_d   = ctrl_q;
      if (MatchWLB(xt_lb, LED_SEG_OFS_LED))    led_d    = xt_lb.wdata[7:0];
      if (MatchWLB(xt_lb, LED_SEG_OFS_DIGITS)) digits_d = xt_lb.wdata;
      if (MatchWLB(xt_lb, LED_SEG_OFS_CTRL))   ctrl_d   = led_seg_ctrl_t'(xt_lb.wdata);
   end

   // Counter chain runs free of register writes so reconfiguration never restarts the scan.
   always_comb begin
      tick       = (ps_q == PS_MAX);
      pc_wrap    = tick && (pc_q == 4'hF);
      idx_wrap   = pc_wrap && (idx_q == 2'd3);
      frame_wrap = idx_wrap && (frame_q == 8'hFF);
      ps_d       = tick ? '0 : ps_q + PS_W'(1);
      pc_d       = tick ? pc_q + 4'd1 : pc_q;
      idx_d      = pc_wrap ? idx_q + 2'd1 : idx_q;
      frame_d    = idx_wrap ? frame_q + 8'd1 : frame_q;
      phase_d    = frame_wrap ? ~phase_q : phase_q;
   end

   always_comb begin
      cur_nib = digits_q[{idx_q, 2'b00} +: 4];
   end

   hex7seg u_hex7seg (
      .hex (cur_nib),
      .seg (cur_glyph)
   );

   // pc == 0 is the blank slot; pc 1..B gives a duty of B/16.
   always_comb begin
      lit = (pc_q != 4'd0) && (pc_q <= ctrl_q.bright) && ctrl_q.en[idx_q]
            && !(ctrl_q.blink[idx_q] && phase_q);
      seg_n_d = '1;
      dig_n_d = '1;
      if (lit) begin
         seg_n_d = ~{ctrl_q.dp[idx_q], cur_glyph};
         dig_n_d = ~(4'b0001 << idx_q);
      end
   end

   always_comb begin
      rdata = '0;
      if (MatchRLB(xt_lb, LED_SEG_OFS_LED))         rdata = {8'h00, led_q};
      else if (MatchRLB(xt_lb, LED_SEG_OFS_DIGITS)) rdata = digits_q;
      else if (MatchRLB(xt_lb, LED_SEG_OFS_CTRL))   rdata = ctrl_q;
      else if (MatchRLB(xt_lb, LED_SEG_OFS_STATUS)) rdata = {13'h0000, phase_q, idx_q};
   end

   always_ff @(posedge lb_clk or posedge rst) begin
      if (rst) begin
         led_q    <= '0;
         digits_q <= '0;
         ctrl_q   <= LED_SEG_CTRL_RST;
         ps_q     <= '0;
         pc_q     <= '0;
         idx_q    <= '0;
         frame_q  <= '0;
         phase_q  <= 1'b0;
         seg_n_q  <= '1;
         dig_n_q  <= '1;
      end else begin
         led_q    <= led_d;
         digits_q <= digits_d;
         ctrl_q   <= ctrl_d;
         ps_q     <= ps_d;
         pc_q     <= pc_d;
         idx_q    <= idx_d;
         frame_q  <= frame_d;
         phase_q  <= phase_d;
         seg_n_q  <= seg_n_d;
         dig_n_q  <= dig_n_d;
      end
   end

   assign led   = led_q;
   assign seg_n = seg_n_q;
   assign dig_n = dig_n_q;

endmodule
